regfile_mrd: RTL and testbench
==============================

// Module: regfile_mrd
// PURPOSE
//  Parametrised register file: 1 write port, NUM_RD read ports, registered (1-cycle) read data.
//  Generalises the 32x16 1W2R collision-checking register file in depth, read-port count and
//  conflict mode (collision-abort or write-first bypass).
//  Adds a sequential clear engine (one address/cycle) that runs after reset or on request.
//  Sits in datapath/scratch storage, fed directly by the issue/control logic.
// PARAMETERS
//  DATA_WIDTH  16  bits per entry
//  ADDR_WIDTH  5   address bits; DEPTH = 2**ADDR_WIDTH entries
//  NUM_RD      2   read ports, >= 1
//  BYPASS      0   0: any address conflict -> abort cycle, flag collision; 1: write-first forwarding
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  resetn     in   1                    asynchronous, active-low reset
//  din        in   DATA_WIDTH           write data
//  wad        in   ADDR_WIDTH           write address
//  wen        in   1                    write enable
//  rad        in   NUM_RD*ADDR_WIDTH    read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  ren        in   NUM_RD               read enables
//  clr        in   1                    request full clear (pulse, sampled when idle)
//  dout       out  NUM_RD*DATA_WIDTH    read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rvalid     out  NUM_RD               dout[i] valid this cycle
//  collision  out  1                    previous-cycle access aborted (BYPASS=0 only)
//  busy       out  1                    clear engine active; all accesses ignored
// BEHAVIOUR
//  Reset (async assert): dout=0, rvalid=0, collision=0, busy=1, FSM=CLEAR, clear ptr=0.
//   Memory array is NOT async-reset; it is zeroed by the clear engine after reset release.
//  FSM {IDLE, CLEAR}:
//   CLEAR: write 0 to mem[ptr] each cycle, ptr++; at ptr==DEPTH-1 write then -> IDLE.
//   Clear takes DEPTH cycles; busy=1 for exactly those cycles (combinational from state).
//   IDLE & clr=1 -> CLEAR, ptr=0, busy rises next cycle; same-cycle wen/ren dropped.
//   clr while CLEAR: ignored (no restart). resetn low mid-clear: restart at ptr=0.
//  While busy: wen/ren ignored, next-cycle dout=0, rvalid=0, collision=0.
//  IDLE access (all outputs registered, 1-cycle latency):
//   Conflict = (wen & ren[i] & wad==rad[i]) for any i, or (ren[i] & ren[j] & rad[i]==rad[j]), i<j.
//   BYPASS=0 & conflict: no write, all dout=0, rvalid=0, collision=1 next cycle.
//   BYPASS=0 & no conflict: mem[wad]<=din if wen; dout[i]=mem[rad[i]], rvalid[i]=1 if ren[i].
//   BYPASS=1: never abort, collision held 0. Write performed; read hitting wad with wen returns
//    din (write-first); read-read same address both return the entry.
//   ren[i]=0 -> dout[i]=0, rvalid[i]=0 next cycle.
//  Write/read addresses span full 2**ADDR_WIDTH; no out-of-range case.
// STRUCTURE
//  Package regfile_pkg: state_t enum {IDLE, CLEAR}; localparam helpers for DEPTH.
//  Sub-module regfile_conflict: combinational, generate-loop pairwise comparators over
//   wen/wad/ren/rad -> per-port wr_hit[NUM_RD] and any_conflict; instanced once.
//  Top: clear FSM + pointer, memory array, read muxes with bypass select, output registers.
// TESTING
//  Reset release -> busy=1 for 32 cycles (defaults), then 0; read any addr -> dout=0, rvalid=1.
//  BYPASS=0: write addr 3 = 0xBEEF; next cycle ren0 rad0=3 -> dout0=0xBEEF, collision=0.
//  BYPASS=0: wen wad=5 din=0x1234 with ren1 rad1=5 -> collision=1, dout=0; later read 5 -> 0.
//  BYPASS=1: same stimulus -> dout1=0x1234, collision=0; read 5 next -> 0x1234.
//  NUM_RD=4, rad0=rad2=7 both ren, BYPASS=0 -> collision=1, all rvalid=0.
//  Fill addr 9=0xAAAA, pulse clr, read 9 during busy -> rvalid=0; after busy drops -> 0x0000;
//   assert resetn low mid-clear -> busy stays 1 for a full fresh 32 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
//   state_t   : clear-engine state (IDLE serves accesses, CLEAR zeroes memory)
//   depth_of  : number of entries for a given address width
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_conflict.sv
// Combinational address-conflict detector for one write port and NUM_RD read ports.
// Ports:
//   wen, wad      : write enable / address
//   ren, rad      : per-port read enables / packed read addresses (port i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   wr_hit        : read port i targets the address being written this cycle
//   any_conflict  : any write-read or read-read address match among active ports
module regfile_conflict
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        wad,
    input  logic [NUM_RD-1:0]            ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
    output logic [NUM_RD-1:0]            wr_hit,
    output logic                         any_conflict
);

    // Upper triangle only (j > i); the rest is tied off so each pair is counted once.
    logic [NUM_RD-1:0][NUM_RD-1:0] rr_hit;

    genvar i, j;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_port
            assign wr_hit[i] = wen & ren[i] & (wad == rad[i*ADDR_WIDTH +: ADDR_WIDTH]);
            for (j = 0; j < NUM_RD; j++) begin : g_pair
                if (j > i) begin : g_cmp
                    assign rr_hit[i][j] = ren[i] & ren[j] &
                        (rad[i*ADDR_WIDTH +: ADDR_WIDTH] == rad[j*ADDR_WIDTH +: ADDR_WIDTH]);
                end else begin : g_tie
                    assign rr_hit[i][j] = 1'b0;
                end
            end
        end
    endgenerate

    assign any_conflict = (|wr_hit) | (|rr_hit);

endmodule

// File: rtl/regfile_mrd.sv
// Register file: 1 write port, NUM_RD read ports, registered read data (1-cycle latency).
// A clear engine zeroes one entry per cycle after reset or on a clr request; while it
// runs (busy=1) all accesses are ignored.
// Ports:
//   clk, resetn     : clock / asynchronous active-low reset
//   din, wad, wen   : write port
//   rad, ren        : read ports (port i address at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   clr             : start a full clear (sampled only when idle)
//   dout, rvalid    : registered read data / valid per port
//   collision       : previous-cycle access aborted on address conflict (BYPASS=0)
//   busy            : clear engine active
module regfile_mrd
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [ADDR_WIDTH-1:0]        wad,
    input  logic                         wen,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
    input  logic [NUM_RD-1:0]            ren,
    input  logic                         clr,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            rvalid,
    output logic                         collision,
    output logic                         busy
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam bit ABORT = (BYPASS == 0);

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_nx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [NUM_RD-1:0]       wr_hit;
    logic                    any_conflict;
    logic                    accept;     // idle cycle that is not a clear request
    logic                    do_access;  // accepted and not aborted

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;

    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] dout_q;

    regfile_conflict #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_conflict (
        .wen          (wen),
        .wad          (wad),
        .ren          (ren),
        .rad          (rad),
        .wr_hit       (wr_hit),
        .any_conflict (any_conflict)
    );

    // Clear engine
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            CLEAR: begin
                ptr_nx = ptr + ADDR_WIDTH'(1);
                if (ptr == ADDR_WIDTH'(DEPTH - 1))
                    state_nx = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    ptr_nx   = '0;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign accept    = (state == IDLE) & ~clr;
    assign do_access = accept & (~ABORT | ~any_conflict);

    // Single memory write port shared by the clear engine and the user write.
    assign mem_we = busy | (do_access & wen);
    assign mem_wa = busy ? ptr : wad;
    assign mem_wd = busy ? '0  : din;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    // Read muxes; in bypass mode a read of the address being written returns din.
    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_rd
            assign rd_data[i] = (!ABORT && wr_hit[i]) ? din
                                                      : mem[rad[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q    <= '0;
            rvalid    <= '0;
            collision <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                dout_q[p] <= (do_access && ren[p]) ? rd_data[p] : '0;
                rvalid[p] <= do_access & ren[p];
            end
            collision <= ABORT & accept & any_conflict;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_regfile_mrd.sv
// Three instances share one stimulus stream:
//   a: defaults (2 ports, abort mode), b: 2 ports bypass mode, c: 4 ports abort mode.
// Each is compared every cycle against an array-based model of the access rules.
module tb_regfile_mrd;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] din;
    logic [AW-1:0] wad;
    logic          wen;
    logic          clr;
    logic [AW-1:0] rad [4];
    logic [3:0]    ren;
    logic [4*AW-1:0] rad_flat;

    assign rad_flat = {rad[3], rad[2], rad[1], rad[0]};

    logic [2*DW-1:0] dout_a, dout_b;
    logic [4*DW-1:0] dout_c;
    logic [1:0]      rvalid_a, rvalid_b;
    logic [3:0]      rvalid_c;
    logic            collision_a, collision_b, collision_c;
    logic            busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    regfile_mrd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .BYPASS(0)) dut_a (
        .clk(clk), .resetn(resetn), .din(din), .wad(wad), .wen(wen),
        .rad(rad_flat[2*AW-1:0]), .ren(ren[1:0]), .clr(clr),
        .dout(dout_a), .rvalid(rvalid_a), .collision(collision_a), .busy(busy_a));

    regfile_mrd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .BYPASS(1)) dut_b (
        .clk(clk), .resetn(resetn), .din(din), .wad(wad), .wen(wen),
        .rad(rad_flat[2*AW-1:0]), .ren(ren[1:0]), .clr(clr),
        .dout(dout_b), .rvalid(rvalid_b), .collision(collision_b), .busy(busy_b));

    regfile_mrd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(4), .BYPASS(0)) dut_c (
        .clk(clk), .resetn(resetn), .din(din), .wad(wad), .wen(wen),
        .rad(rad_flat), .ren(ren), .clr(clr),
        .dout(dout_c), .rvalid(rvalid_c), .collision(collision_c), .busy(busy_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state per instance: memory contents and remaining clear cycles.
    logic [DW-1:0] mm [3][DEPTH];
    int            mclr [3];
    logic [63:0]   ed [3];
    logic [3:0]    ev [3];
    logic          ec [3];

    // Predict the outputs after the coming rising edge from current inputs.
    task automatic model_step(input int id, input int nrd, input bit byp);
        bit conf;
        conf   = 1'b0;
        ed[id] = '0;
        ev[id] = '0;
        ec[id] = 1'b0;
        if (!resetn) begin
            mclr[id] = DEPTH;
        end else if (mclr[id] > 0) begin
            mm[id][DEPTH - mclr[id]] = '0;
            mclr[id]--;
        end else if (clr) begin
            mclr[id] = DEPTH;
        end else begin
            for (int i = 0; i < nrd; i++) begin
                if (wen && ren[i] && wad == rad[i]) conf = 1'b1;
                for (int j = i + 1; j < nrd; j++)
                    if (ren[i] && ren[j] && rad[i] == rad[j]) conf = 1'b1;
            end
            if (!byp && conf) begin
                ec[id] = 1'b1;
            end else begin
                for (int i = 0; i < nrd; i++) begin
                    if (ren[i]) begin
                        ev[id][i] = 1'b1;
                        ed[id][i*DW +: DW] = (byp && wen && wad == rad[i]) ? din : mm[id][rad[i]];
                    end
                end
                if (wen) mm[id][wad] = din;
            end
        end
    endtask

    task automatic check_all();
        chk("a.dout",   64'(dout_a),      ed[0]);
        chk("a.rvalid", 64'(rvalid_a),    64'(ev[0][1:0]));
        chk("a.coll",   64'(collision_a), 64'(ec[0]));
        chk("a.busy",   64'(busy_a),      64'(mclr[0] != 0));
        chk("b.dout",   64'(dout_b),      ed[1]);
        chk("b.rvalid", 64'(rvalid_b),    64'(ev[1][1:0]));
        chk("b.coll",   64'(collision_b), 64'(ec[1]));
        chk("b.busy",   64'(busy_b),      64'(mclr[1] != 0));
        chk("c.dout",   64'(dout_c),      ed[2]);
        chk("c.rvalid", 64'(rvalid_c),    64'(ev[2]));
        chk("c.coll",   64'(collision_c), 64'(ec[2]));
        chk("c.busy",   64'(busy_c),      64'(mclr[2] != 0));
    endtask

    task automatic cyc();
        model_step(0, 2, 1'b0);
        model_step(1, 2, 1'b1);
        model_step(2, 4, 1'b0);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        wen = 1'b0; wad = '0; din = '0; clr = 1'b0; ren = '0;
        for (int i = 0; i < 4; i++) rad[i] = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mclr[k] = DEPTH; ed[k] = '0; ev[k] = '0; ec[k] = 1'b0;
        end
        #1;
        check_all();
    endtask

    initial begin
        int n;
        idle_in();
        for (int k = 0; k < 3; k++) mclr[k] = DEPTH;
        @(posedge clk); #1;
        do_reset();
        cyc(); cyc();
        resetn = 1'b1;

        // Initial clear: reads are ignored while busy.
        ren = 2'b11; rad[0] = 5'd4; rad[1] = 5'd20;
        n = 0;
        while (busy_a && n < 100) begin cyc(); n++; end
        chk("init_clear_len", 64'(n), 64'd32);

        // Any address reads back zero after the clear.
        cyc();
        chk("post_clear_rv", 64'(rvalid_a), 64'b11);
        chk("post_clear_d",  64'(dout_a),   64'd0);

        // Write 3 then read it.
        idle_in(); wen = 1'b1; wad = 5'd3; din = 16'hBEEF; cyc();
        idle_in(); ren[0] = 1'b1; rad[0] = 5'd3; cyc();
        chk("beef_a", 64'(dout_a[15:0]), 64'hBEEF);
        chk("beef_b", 64'(dout_b[15:0]), 64'hBEEF);
        chk("beef_coll", 64'(collision_a), 64'd0);

        // Write-read conflict: abort vs forward.
        idle_in(); wen = 1'b1; wad = 5'd5; din = 16'h1234; ren[1] = 1'b1; rad[1] = 5'd5; cyc();
        chk("wr_coll_a", 64'(collision_a), 64'd1);
        chk("wr_dout_a", 64'(dout_a), 64'd0);
        chk("fwd_b",     64'(dout_b[31:16]), 64'h1234);
        chk("fwd_coll_b", 64'(collision_b), 64'd0);
        idle_in(); ren[0] = 1'b1; rad[0] = 5'd5; cyc();
        chk("rd5_a", 64'(dout_a[15:0]), 64'd0);
        chk("rd5_b", 64'(dout_b[15:0]), 64'h1234);

        // Read-read conflict on ports 0 and 2 of the 4-port instance.
        idle_in(); ren = 4'b0101; rad[0] = 5'd7; rad[2] = 5'd7; cyc();
        chk("rr_coll_c", 64'(collision_c), 64'd1);
        chk("rr_rv_c",   64'(rvalid_c),    64'd0);

        // Randomized traffic over a narrow address range to provoke conflicts.
        repeat (400) begin
            wen = 1'($urandom_range(0, 1));
            wad = AW'($urandom_range(0, 7));
            din = DW'($urandom);
            for (int i = 0; i < 4; i++) begin
                ren[i] = 1'($urandom_range(0, 1));
                rad[i] = AW'($urandom_range(0, 7));
            end
            clr = ($urandom_range(0, 59) == 0);
            cyc();
        end

        // Let any pending clear finish.
        idle_in();
        n = 0;
        while (busy_a && n < 100) begin cyc(); n++; end
        chk("rand_drain", 64'(busy_a), 64'd0);

        // Fill 9, request clear, read during busy, reset mid-clear.
        idle_in(); wen = 1'b1; wad = 5'd9; din = 16'hAAAA; cyc();
        idle_in(); clr = 1'b1; cyc();
        chk("clr_busy", 64'(busy_a), 64'd1);
        idle_in(); ren[0] = 1'b1; rad[0] = 5'd9;
        clr = 1'b1;  // ignored while already clearing
        repeat (10) cyc();
        chk("busy_rv", 64'(rvalid_a), 64'd0);
        do_reset();
        cyc(); cyc();
        resetn = 1'b1;
        n = 0;
        while (busy_a && n < 100) begin cyc(); n++; end
        chk("fresh_clear_len", 64'(n), 64'd32);
        clr = 1'b0;
        cyc();
        chk("clr9_rv", 64'(rvalid_a), 64'b01);
        chk("clr9_d",  64'(dout_a[15:0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
